// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator: per-channel divisor, enable,
// one-cycle tick pulse and 50%-duty toggle, with runtime config and global sync.
module multi_tick_gen #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = $clog2(CLK_FREQ) + 1,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] toggle,
    output logic              cfg_err
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(CLK_FREQ);

    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] en_q;
    logic              wr_ok;
    logic              bad_wr;

    always_comb begin
        wr_ok  = cfg_we && (cfg_div != '0) && (32'(cfg_ch) < NUM_CH);
        bad_wr = cfg_we && !wr_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i]  <= DIV_RST;
                en_q[i]   <= 1'b1;
                cnt_q[i]  <= '0;
                tick[i]   <= 1'b0;
                toggle[i] <= 1'b0;
            end
        end else begin
            cfg_err <= bad_wr;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_ok && (32'(cfg_ch) == i)) begin
                    // toggle phase is kept across reconfiguration
                    div_q[i] <= cfg_div;
                    en_q[i]  <= cfg_en;
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b0;
                end else if (sync) begin
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b0;
                end else if (!en_q[i]) begin
                    tick[i]  <= 1'b0;
                end else if (cnt_q[i] == div_q[i] - ONE) begin
                    cnt_q[i]  <= '0;
                    tick[i]   <= 1'b1;
                    toggle[i] <= ~toggle[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + ONE;
                    tick[i]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Scoreboard bench for multi_tick_gen: stimulus pushes per-edge expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multi_tick_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_en = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] tick;
    logic [3:0] toggle;
    logic       cfg_err;

    logic       cfg3_we = 1'b0;
    logic [1:0] cfg3_ch = '0;
    logic [7:0] cfg3_div = '0;
    logic [2:0] tick3;
    logic [2:0] toggle3;
    logic       cfg_err3;

    multi_tick_gen #(.CLK_FREQ(10), .NUM_CH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_en(cfg_en), .sync(sync), .tick(tick), .toggle(toggle), .cfg_err(cfg_err)
    );

    // three channels so that an out-of-range index is representable on cfg_ch
    multi_tick_gen #(.CLK_FREQ(10), .NUM_CH(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .cfg_we(cfg3_we), .cfg_ch(cfg3_ch), .cfg_div(cfg3_div),
        .cfg_en(1'b1), .sync(1'b0), .tick(tick3), .toggle(toggle3), .cfg_err(cfg_err3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned c;
        int unsigned n;
        int unsigned kind;
        logic [3:0]  exp;
        logic [3:0]  care;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned base = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int unsigned k);
        case (k)
            0: return "tick";
            1: return "toggle";
            2: return "cfg_err";
            default: return "cfg_err_3ch";
        endcase
    endfunction

    exp_t       m_e;
    logic [3:0] m_act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            m_e = sb.pop_front();
            case (m_e.kind)
                0: m_act = tick;
                1: m_act = toggle;
                2: m_act = {3'b000, cfg_err};
                default: m_act = {3'b000, cfg_err3};
            endcase
            checks++;
            if (m_e.c != cyc || (m_act & m_e.care) != (m_e.exp & m_e.care)) begin
                errors++;
                $display("FAIL %s edge=%0d got=%b exp=%b care=%b", kname(m_e.kind), m_e.n,
                         m_act & m_e.care, m_e.exp & m_e.care, m_e.care);
            end
        end
    end

    task automatic push(input int unsigned n, input int unsigned kind,
                        input logic [3:0] exp, input logic [3:0] care);
        exp_t e;
        e.c = base + n; e.n = n; e.kind = kind; e.exp = exp; e.care = care;
        sb.push_back(e);
    endtask

    task automatic wait_rel(input int unsigned n);
        int unsigned guard = 0;
        while (cyc != base + n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("FAIL wait_edge edge=%0d got_cyc=%0d exp_cyc=%0d", n, cyc, base + n);
        end
    endtask

    // reset for two edges; edge 1 is the first posedge after release
    task automatic start();
        rst = 1'b1;
        @(negedge clk);
        base = cyc + 1;
        push(0, 0, 4'h0, 4'hF);
        push(0, 1, 4'h0, 4'hF);
        push(0, 2, 4'h0, 4'h1);
        push(0, 3, 4'h0, 4'h1);
        @(negedge clk);
        base = cyc;
        rst = 1'b0;
    endtask

    task automatic write(input int unsigned k, input logic [1:0] ch,
                         input logic [7:0] dv, input logic en);
        wait_rel(k - 1);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_en = en;
        wait_rel(k);
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0;
    endtask

    task automatic write3(input int unsigned k, input logic [1:0] ch, input logic [7:0] dv);
        wait_rel(k - 1);
        cfg3_we = 1'b1; cfg3_ch = ch; cfg3_div = dv;
        wait_rel(k);
        cfg3_we = 1'b0; cfg3_ch = '0; cfg3_div = '0;
    endtask

    logic [3:0] t;
    logic [3:0] g;

    initial begin
        // default divisor 10 on every channel
        start();
        for (int unsigned n = 1; n <= 31; n++) begin
            push(n, 0, (n % 10 == 0) ? 4'hF : 4'h0, 4'hF);
            push(n, 1, ((n >= 10 && n < 20) || n >= 30) ? 4'hF : 4'h0, 4'hF);
            push(n, 2, 4'h0, 4'h1);
        end
        wait_rel(31);

        // ch1 divisor 3 written at edge 5
        start();
        for (int unsigned n = 1; n <= 22; n++) begin
            t = (n % 10 == 0) ? 4'hF : 4'h0;
            t[1] = (n >= 8) && ((n - 8) % 3 == 0);
            g = (n >= 10 && n < 20) ? 4'hF : 4'h0;
            g[1] = (n >= 8) && ((((n - 8) / 3 + 1) % 2) == 1);
            push(n, 0, t, 4'hF);
            push(n, 1, g, 4'hF);
        end
        write(5, 2'd1, 8'd3, 1'b1);
        wait_rel(22);

        // ch2 divisor 1 written at edge 3
        start();
        for (int unsigned n = 1; n <= 14; n++) begin
            t = (n % 10 == 0) ? 4'hF : 4'h0;
            t[2] = (n >= 4);
            g = (n >= 10) ? 4'hF : 4'h0;
            g[2] = (n >= 4) && ((n - 4) % 2 == 0);
            push(n, 0, t, 4'hF);
            push(n, 1, g, 4'hF);
        end
        write(3, 2'd2, 8'd1, 1'b1);
        wait_rel(14);

        // ch3 paused at 4, sync at 6, ch3 re-enabled at 20
        start();
        for (int unsigned n = 1; n <= 37; n++) begin
            t = (n > 6 && (n - 6) % 10 == 0) ? 4'hF : 4'h0;
            t[3] = (n == 30);
            g = ((n >= 16 && n < 26) || n >= 36) ? 4'hF : 4'h0;
            g[3] = (n >= 30);
            push(n, 0, t, 4'hF);
            push(n, 1, g, 4'hF);
        end
        write(4, 2'd3, 8'd10, 1'b0);
        wait_rel(5);
        sync = 1'b1;
        wait_rel(6);
        sync = 1'b0;
        write(20, 2'd3, 8'd10, 1'b1);
        wait_rel(37);

        // rejected writes: zero divisor, out-of-range channel
        start();
        for (int unsigned n = 1; n <= 25; n++) begin
            push(n, 0, (n % 10 == 0) ? 4'hF : 4'h0, 4'hF);
            push(n, 1, (n >= 10 && n < 20) ? 4'hF : 4'h0, 4'hF);
            push(n, 2, (n == 3 || n == 12) ? 4'h1 : 4'h0, 4'h1);
            push(n, 3, (n == 5) ? 4'h1 : 4'h0, 4'h1);
        end
        write(3, 2'd0, 8'd0, 1'b0);
        write3(5, 2'd3, 8'd5);
        write3(8, 2'd2, 8'd5);
        write(12, 2'd2, 8'd0, 1'b0);
        wait_rel(25);

        // ch1 divisor 3 at edge 1, reset asserted for edge 7
        start();
        for (int unsigned n = 1; n <= 28; n++) begin
            if (n < 7) begin
                t = 4'h0; t[1] = (n == 4);
                g = 4'h0; g[1] = (n >= 4);
            end else begin
                t = (n == 17 || n == 27) ? 4'hF : 4'h0;
                g = (n >= 17 && n < 27) ? 4'hF : 4'h0;
            end
            push(n, 0, t, 4'hF);
            push(n, 1, g, 4'hF);
            push(n, 2, 4'h0, 4'h1);
        end
        write(1, 2'd1, 8'd3, 1'b1);
        wait_rel(6);
        rst = 1'b1;
        wait_rel(7);
        rst = 1'b0;
        wait_rel(28);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
